// File: rtl/arb_pkg.sv
// Shared constants and types for the priority / round-robin arbiter.
// Holds the parameter defaults, the FSM state encoding and a small helper.
package arb_pkg;

  localparam int NREQ_DEFAULT     = 3;
  localparam int PW_DEFAULT       = 2;
  localparam int MAX_HOLD_DEFAULT = 8;
  localparam int HOLD_W           = 8;
  localparam int IDX_W            = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Last hold-count value before a forced re-arbitration.
  function automatic logic [HOLD_W-1:0] hold_limit(input int max_hold);
    return HOLD_W'(max_hold - 1);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: highest priority among eligible requesters,
// ties resolved in round-robin order starting just after the last winner.
module arb_pick
  import arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int PW   = PW_DEFAULT
) (
  input  logic [NREQ-1:0]    elig,
  input  logic [NREQ*PW-1:0] prio,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   win
);

  logic [PW-1:0] prio_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign prio_arr[gi] = prio[PW*gi +: PW];
  end

  // Strict '>' keeps the earliest candidate in search order on a tie.
  always_comb begin
    logic [PW-1:0]    best;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    best  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDX_W'((int'(last) + 1 + k) % NREQ);
      if (elig[idx] && (!found || prio_arr[idx] > best)) begin
        found = 1'b1;
        best  = prio_arr[idx];
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/arbiter_prio_rr.sv
// Non-preemptive priority arbiter with round-robin tie-break and a bounded
// ownership time; grant, valid and owner are all registered.
module arbiter_prio_rr
  import arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEFAULT,
  parameter int PW       = PW_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*PW-1:0] prio,
  output logic [NREQ-1:0]    gnt,
  output logic               valid,
  output logic [IDX_W-1:0]   owner
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = hold_limit(MAX_HOLD);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  owner_reg, owner_next;
  logic [IDX_W-1:0]  last_reg, last_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;

  logic [NREQ-1:0]   owner_onehot;
  logic [NREQ-1:0]   elig;
  logic              owner_req, others, timeout, arb;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_win;

  assign owner_onehot = NREQ'(1) << owner_reg;
  assign owner_req    = req[owner_reg];
  assign others       = |(req & ~owner_onehot);
  assign timeout      = (state_reg == BUSY) && (hold_reg == HOLD_MAX);
  assign arb          = (state_reg == IDLE) || !owner_req || timeout;
  // A timed-out owner steps aside only if someone else is waiting.
  assign elig         = (timeout && owner_req && others) ? (req & ~owner_onehot) : req;

  arb_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .elig  (elig),
    .prio  (prio),
    .last  (last_reg),
    .found (pick_found),
    .win   (pick_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= IDX_W'(NREQ - 1);
      hold_reg  <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
      gnt_reg   <= gnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    gnt_next   = gnt_reg;
    if (arb) begin
      hold_next = '0;
      if (pick_found) begin
        state_next = BUSY;
        owner_next = pick_win;
        last_next  = pick_win;
        gnt_next   = NREQ'(1) << pick_win;
      end else begin
        state_next = IDLE;
        owner_next = '0;
        gnt_next   = '0;
      end
    end else begin
      hold_next = hold_reg + HOLD_W'(1);
    end
  end

  always_comb begin
    gnt   = gnt_reg;
    valid = (state_reg == BUSY);
    owner = owner_reg;
  end

endmodule
